// File: rtl/instr_decode_stage_pkg.sv
// instr_decode_stage_pkg: opcode map, field positions and decoded bundle shared by decode and execute.
package instr_decode_stage_pkg;

    localparam int OPC_HI = 8;
    localparam int OPC_LO = 6;
    localparam int RA_HI  = 5;
    localparam int RA_LO  = 3;
    localparam int RB_HI  = 2;
    localparam int RB_LO  = 0;
    localparam int OFS_HI = 5;

    localparam logic [2:0] OPC_RSH = 3'b000;
    localparam logic [2:0] OPC_XOR = 3'b001;
    localparam logic [2:0] OPC_ADD = 3'b010;
    localparam logic [2:0] OPC_AND = 3'b011;
    localparam logic [2:0] OPC_BRE = 3'b100;
    localparam logic [2:0] OPC_ILL = 3'b101;
    localparam logic [2:0] OPC_J   = 3'b110;
    localparam logic [2:0] OPC_CLR = 3'b111;

    typedef enum logic [2:0] {
        OP_RSH = OPC_RSH,
        OP_XOR = OPC_XOR,
        OP_ADD = OPC_ADD,
        OP_AND = OPC_AND,
        OP_BRE = OPC_BRE,
        OP_J   = OPC_J,
        OP_CLR = OPC_CLR
    } op_mne_e;

    typedef struct packed {
        op_mne_e    op;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [7:0] imm;
        logic       reg_we;
        logic       branch;
        logic       jump;
        logic       illegal;
    } bundle_t;

endpackage

// File: rtl/instr_decode_stage_decoder.sv
// instr_decoder: pure combinational mapping of a raw instruction word to the decoded bundle.
module instr_decoder
    import instr_decode_stage_pkg::*;
#(
    parameter int IW = 9
) (
    input  logic [IW-1:0] i_instr,
    output bundle_t       o_dec
);

    logic [2:0] w_opc;
    logic       w_ctl;

    assign w_opc = i_instr[OPC_HI:OPC_LO];
    assign w_ctl = (w_opc == OPC_BRE) || (w_opc == OPC_J);

    // Illegal words masquerade as ADD with every side effect suppressed.
    always_comb begin
        o_dec         = '0;
        o_dec.ra      = i_instr[RA_HI:RA_LO];
        o_dec.rb      = (w_opc == OPC_CLR) ? 3'd0 : i_instr[RB_HI:RB_LO];
        o_dec.illegal = w_opc == OPC_ILL;
        o_dec.op      = (w_opc == OPC_ILL) ? OP_ADD : op_mne_e'(w_opc);
        o_dec.branch  = w_opc == OPC_BRE;
        o_dec.jump    = w_opc == OPC_J;
        o_dec.reg_we  = !w_ctl && (w_opc != OPC_ILL);
        o_dec.imm     = w_ctl ? {{2{i_instr[OFS_HI]}}, i_instr[OFS_HI:0]} : 8'd0;
    end

endmodule

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: registered decode stage with a one-entry skid so in_ready comes from a flop.
module instr_decode_stage
    import instr_decode_stage_pkg::*;
#(
    parameter int IW = 9,
    parameter int CW = 16
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic          in_valid,
    input  logic [IW-1:0] in_instr,
    output logic          in_ready,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2:0]    out_op,
    output logic [2:0]    out_ra,
    output logic [2:0]    out_rb,
    output logic [7:0]    out_imm,
    output logic          out_reg_we,
    output logic          out_branch,
    output logic          out_jump,
    output logic          out_illegal,
    output logic          err_sticky,
    output logic [CW-1:0] retired_cnt
);

    bundle_t       w_dec;
    bundle_t       r_out;
    bundle_t       r_skid;
    logic          r_out_valid;
    logic          r_skid_valid;
    logic          r_err;
    logic [CW-1:0] r_cnt;
    logic          w_acc;
    logic          w_fire;
    logic          w_load;

    instr_decoder #(.IW(IW)) u_dec (
        .i_instr (in_instr),
        .o_dec   (w_dec)
    );

    assign w_acc  = in_valid && !r_skid_valid;
    assign w_fire = r_out_valid && out_ready;
    assign w_load = !r_out_valid || out_ready;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_out        <= '0;
            r_skid       <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
        end else begin
            if (w_fire) r_cnt <= r_cnt + 1'b1;
            if (w_fire && r_out.illegal) r_err <= 1'b1;
            // A handshake on the flush edge retires normally; only held work is discarded.
            if (flush) begin
                r_out_valid  <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (w_load) begin
                r_out_valid  <= r_skid_valid || w_acc;
                r_skid_valid <= 1'b0;
                if (r_skid_valid) r_out <= r_skid;
                else if (w_acc) r_out <= w_dec;
            end else if (w_acc) begin
                r_skid       <= w_dec;
                r_skid_valid <= 1'b1;
            end
        end
    end

    assign in_ready    = !r_skid_valid;
    assign out_valid   = r_out_valid;
    assign out_op      = r_out.op;
    assign out_ra      = r_out.ra;
    assign out_rb      = r_out.rb;
    assign out_imm     = r_out.imm;
    assign out_reg_we  = r_out.reg_we;
    assign out_branch  = r_out.branch;
    assign out_jump    = r_out.jump;
    assign out_illegal = r_out.illegal;
    assign err_sticky  = r_err;
    assign retired_cnt = r_cnt;

endmodule
